// File: rtl/spi_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_burst_sequencer
// Purpose  : Queues multi-byte SPI bursts around a byte-level engine, owning
//            chip-select timing plus TX/RX byte FIFOs.
// Revision : 1.0
// ============================================================================
module spi_burst_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                          raw_clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_push,
  output logic                          tx_full,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic [7:0]                    rx_data,
  input  logic                          rx_pop,
  output logic                          rx_empty,
  input  logic                          go,
  input  logic                          clear_flags,
  output logic                          busy,
  output logic                          rx_overflow,
  output logic                          ack_error,
  output logic                          cs_n,
  output logic                          spi_start,
  output logic [7:0]                    spi_data_tx,
  input  logic                          spi_busy,
  input  logic [7:0]                    spi_data_rx
);

  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = AW + 1;
  localparam int SETUP_CYC = (CS_SETUP < 1) ? 1 : CS_SETUP;
  localparam int HOLD_CYC  = (CS_HOLD < 1) ? 1 : CS_HOLD;
  localparam int ACK_LIM   = (ACK_TIMEOUT < 1) ? 1 : ACK_TIMEOUT;
  localparam int CNT_MAX   = (SETUP_CYC > HOLD_CYC)
                           ? ((SETUP_CYC > ACK_LIM) ? SETUP_CYC : ACK_LIM)
                           : ((HOLD_CYC > ACK_LIM) ? HOLD_CYC : ACK_LIM);
  localparam int TW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SETUP     = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_HOLD      = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          cs_n_q, cs_n_d;
  logic          spi_start_q, spi_start_d;
  logic [7:0]    spi_data_tx_q, spi_data_tx_d;
  logic          rx_overflow_q, rx_overflow_d;
  logic          ack_error_q, ack_error_d;

  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [7:0]    tx_mem_d [FIFO_DEPTH];
  logic [AW-1:0] tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
  logic [CW-1:0] tx_count_q, tx_count_d;
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [7:0]    rx_mem_d [FIFO_DEPTH];
  logic [AW-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
  logic [CW-1:0] rx_count_q, rx_count_d;

  logic tx_push_ok, tx_pop, tx_flush;
  logic rx_full, rx_pop_ok, rx_wr, rx_wr_ok, ovf_set, ack_set, end_burst;

  assign tx_full    = (tx_count_q == DEPTH_C);
  assign tx_push_ok = tx_push && !tx_full;
  assign rx_full    = (rx_count_q == DEPTH_C);
  assign rx_empty   = (rx_count_q == '0);
  assign rx_pop_ok  = rx_pop && !rx_empty;
  // A same-cycle pop frees the slot, so a capture into a full FIFO still lands.
  assign rx_wr_ok   = rx_wr && (!rx_full || rx_pop_ok);
  assign ovf_set    = rx_wr && rx_full && !rx_pop_ok;

  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    cs_n_d        = cs_n_q;
    spi_start_d   = spi_start_q;
    spi_data_tx_d = spi_data_tx_q;
    tx_pop        = 1'b0;
    tx_flush      = 1'b0;
    rx_wr         = 1'b0;
    ack_set       = 1'b0;
    end_burst     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go && (tx_count_q != '0)) begin
          cs_n_d = 1'b0;
          if (SETUP_CYC == 1) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_SETUP;
            tmr_d   = TW'(SETUP_CYC - 1);
          end
        end
      end
      // The LOAD cycle is the last setup cycle, hence leaving at a count of 1.
      ST_SETUP: begin
        if (tmr_q <= TMR_ONE) state_d = ST_LOAD;
        else                  tmr_d   = tmr_q - TMR_ONE;
      end
      ST_LOAD: begin
        spi_data_tx_d = tx_mem_q[tx_rd_q];
        tx_pop        = 1'b1;
        spi_start_d   = 1'b1;
        tmr_d         = '0;
        state_d       = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (spi_busy) begin
          spi_start_d = 1'b0;
          state_d     = ST_WAIT_DONE;
        end else if (tmr_q == TW'(ACK_LIM - 1)) begin
          spi_start_d = 1'b0;
          ack_set     = 1'b1;
          tx_flush    = 1'b1;
          end_burst   = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!spi_busy) begin
          rx_wr = 1'b1;
          if ((tx_count_q != '0) || tx_push_ok) state_d   = ST_LOAD;
          else                                  end_burst = 1'b1;
        end
      end
      ST_HOLD: begin
        if (tmr_q <= TMR_ONE) begin
          cs_n_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The cycle that observes the end of the last byte counts as the first hold cycle.
    if (end_burst) begin
      if (HOLD_CYC == 1) begin
        cs_n_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        state_d = ST_HOLD;
        tmr_d   = TW'(HOLD_CYC - 1);
      end
    end
  end

  always_comb begin
    tx_mem_d   = tx_mem_q;
    tx_rd_d    = tx_rd_q;
    tx_wr_d    = tx_wr_q;
    tx_count_d = tx_count_q;
    if (tx_flush) begin
      tx_rd_d    = '0;
      tx_wr_d    = '0;
      tx_count_d = '0;
    end else begin
      if (tx_push_ok) begin
        tx_mem_d[tx_wr_q] = tx_data;
        tx_wr_d           = tx_wr_q + AW'(1);
      end
      if (tx_pop) tx_rd_d = tx_rd_q + AW'(1);
      tx_count_d = tx_count_q + CW'(tx_push_ok) - CW'(tx_pop);
    end

    rx_mem_d = rx_mem_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    if (rx_wr_ok) begin
      rx_mem_d[rx_wr_q] = spi_data_rx;
      rx_wr_d           = rx_wr_q + AW'(1);
    end
    if (rx_pop_ok) rx_rd_d = rx_rd_q + AW'(1);
    rx_count_d = rx_count_q + CW'(rx_wr_ok) - CW'(rx_pop_ok);

    rx_overflow_d = (rx_overflow_q && !clear_flags) || ovf_set;
    ack_error_d   = (ack_error_q && !clear_flags) || ack_set;
  end

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      tmr_q         <= '0;
      cs_n_q        <= 1'b1;
      spi_start_q   <= 1'b0;
      spi_data_tx_q <= '0;
      rx_overflow_q <= 1'b0;
      ack_error_q   <= 1'b0;
      tx_mem_q      <= '{default: '0};
      tx_rd_q       <= '0;
      tx_wr_q       <= '0;
      tx_count_q    <= '0;
      rx_mem_q      <= '{default: '0};
      rx_rd_q       <= '0;
      rx_wr_q       <= '0;
      rx_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      cs_n_q        <= cs_n_d;
      spi_start_q   <= spi_start_d;
      spi_data_tx_q <= spi_data_tx_d;
      rx_overflow_q <= rx_overflow_d;
      ack_error_q   <= ack_error_d;
      tx_mem_q      <= tx_mem_d;
      tx_rd_q       <= tx_rd_d;
      tx_wr_q       <= tx_wr_d;
      tx_count_q    <= tx_count_d;
      rx_mem_q      <= rx_mem_d;
      rx_rd_q       <= rx_rd_d;
      rx_wr_q       <= rx_wr_d;
      rx_count_q    <= rx_count_d;
    end
  end

  assign tx_count    = tx_count_q;
  assign rx_data     = rx_mem_q[rx_rd_q];
  assign busy        = (state_q != ST_IDLE);
  assign rx_overflow = rx_overflow_q;
  assign ack_error   = ack_error_q;
  assign cs_n        = cs_n_q;
  assign spi_start   = spi_start_q;
  assign spi_data_tx = spi_data_tx_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_burst_sequencer
// Purpose  : Directed self-checking bench with an echoing byte-engine model.
// Revision : 1.0
// ============================================================================
module tb_spi_burst_sequencer;

  localparam int BUSY_LEN = 8;

  logic       raw_clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_push = 1'b0;
  logic       rx_pop = 1'b0;
  logic       go = 1'b0;
  logic       clear_flags = 1'b0;
  logic       tx_full, rx_empty, busy, rx_overflow, ack_error, cs_n, spi_start;
  logic [2:0] tx_count;
  logic [7:0] rx_data, spi_data_tx;

  // Engine model: echoes the byte it was started with after BUSY_LEN busy cycles.
  logic       eng_ack_en = 1'b1;
  logic       eng_busy = 1'b0;
  logic [7:0] eng_rx = 8'h00;
  int         eng_cnt = 0;

  always #5 raw_clk = ~raw_clk;

  always @(posedge raw_clk) begin
    if (eng_busy) begin
      if (eng_cnt == 1) eng_busy <= 1'b0;
      eng_cnt <= eng_cnt - 1;
    end else if (spi_start && eng_ack_en) begin
      eng_busy <= 1'b1;
      eng_cnt  <= BUSY_LEN;
      eng_rx   <= spi_data_tx;
    end
  end

  spi_burst_sequencer #(
    .FIFO_DEPTH(4), .CS_SETUP(2), .CS_HOLD(2), .ACK_TIMEOUT(15)
  ) dut (
    .raw_clk(raw_clk), .reset(reset),
    .tx_data(tx_data), .tx_push(tx_push), .tx_full(tx_full), .tx_count(tx_count),
    .rx_data(rx_data), .rx_pop(rx_pop), .rx_empty(rx_empty),
    .go(go), .clear_flags(clear_flags), .busy(busy),
    .rx_overflow(rx_overflow), .ack_error(ack_error), .cs_n(cs_n),
    .spi_start(spi_start), .spi_data_tx(spi_data_tx),
    .spi_busy(eng_busy), .spi_data_rx(eng_rx)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Activity monitor, updated once per falling edge.
  int         cyc = 0;
  logic       p_cs, p_start, p_sbusy;
  int         cs_fall_cyc, cs_rise_cyc, cs_falls, cs_rises, start_hi;
  int         start_cyc[$];
  int         busy_fall_cyc[$];
  logic [7:0] tx_log[$];

  task automatic clear_mon();
    p_cs = cs_n; p_start = spi_start; p_sbusy = eng_busy;
    cs_fall_cyc = 0; cs_rise_cyc = 0; cs_falls = 0; cs_rises = 0; start_hi = 0;
    start_cyc.delete(); busy_fall_cyc.delete(); tx_log.delete();
  endtask

  task automatic step();
    @(negedge raw_clk);
    cyc++;
    if (p_cs && !cs_n) begin cs_fall_cyc = cyc; cs_falls++; end
    if (!p_cs && cs_n) begin cs_rise_cyc = cyc; cs_rises++; end
    if (!p_start && spi_start) begin
      start_cyc.push_back(cyc);
      tx_log.push_back(spi_data_tx);
    end
    if (spi_start) start_hi++;
    if (p_sbusy && !eng_busy) busy_fall_cyc.push_back(cyc);
    p_cs = cs_n; p_start = spi_start; p_sbusy = eng_busy;
  endtask

  task automatic push(input logic [7:0] b);
    tx_data = b; tx_push = 1'b1;
    step();
    tx_push = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_nonempty"}, rx_empty, 1'b0);
    check(tag, rx_data, exp);
    rx_pop = 1'b1;
    step();
    rx_pop = 1'b0;
  endtask

  task automatic finish_burst(input string tag);
    int n = 0;
    while (busy && n < 300) begin step(); n++; end
    check({tag, "_done"}, busy, 1'b0);
  endtask

  task automatic run_burst(input string tag);
    go = 1'b1;
    step();
    go = 1'b0;
    finish_burst(tag);
  endtask

  // WAIT_DONE is the only state where the engine is busy and spi_start is low.
  task automatic wait_wait_done(input string tag);
    int n = 0;
    while (!(eng_busy && !spi_start && busy) && n < 50) begin step(); n++; end
    check({tag, "_reach"}, (n < 50), 1'b1);
  endtask

  initial begin
    // ---------------- reset state ----------------
    reset = 1'b1;
    step(); step();
    check("rst_tx_full",  tx_full, 1'b0);
    check("rst_tx_count", tx_count, 3'd0);
    check("rst_rx_empty", rx_empty, 1'b1);
    check("rst_ctl", {cs_n, spi_start, busy, rx_overflow, ack_error}, 5'b10000);
    check("rst_data_tx", spi_data_tx, 8'h00);
    reset = 1'b0;
    step();

    // ---------------- single byte ----------------
    clear_mon();
    push(8'hA5);
    check("t1_count", tx_count, 3'd1);
    run_burst("t1");
    check("t1_starts", start_cyc.size(), 1);
    check("t1_setup", start_cyc[0] - cs_fall_cyc, 2);
    check("t1_byte", tx_log[0], 8'hA5);
    check("t1_hold", cs_rise_cyc - busy_fall_cyc[0], 2);
    check("t1_cs_idle", cs_n, 1'b1);
    check("t1_tx_held", spi_data_tx, 8'hA5);
    pop_expect("t1_rx", 8'hA5);
    check("t1_rx_empty", rx_empty, 1'b1);

    // ---------------- three-byte burst ----------------
    clear_mon();
    push(8'h01); push(8'h02); push(8'h03);
    run_burst("t2");
    check("t2_starts", start_cyc.size(), 3);
    check("t2_cs_falls", cs_falls, 1);
    check("t2_cs_rises", cs_rises, 1);
    // 1 (LOAD) + 2 (ack latency) + 8 (engine busy)
    check("t2_period01", start_cyc[1] - start_cyc[0], 11);
    check("t2_period12", start_cyc[2] - start_cyc[1], 11);
    // Busy low is seen one edge later; the LOAD cycle then precedes spi_start.
    check("t2_gap", start_cyc[1] - busy_fall_cyc[0], 2);
    check("t2_b2", tx_log[2], 8'h03);
    pop_expect("t2_rx0", 8'h01);
    pop_expect("t2_rx1", 8'h02);
    pop_expect("t2_rx2", 8'h03);

    // ---------------- FIFO full / RX overflow ----------------
    clear_mon();
    push(8'h10); push(8'h11); push(8'h12);
    check("t3_not_full", tx_full, 1'b0);
    push(8'h13);
    check("t3_full", tx_full, 1'b1);
    push(8'hFF);
    check("t3_full_count", tx_count, 3'd4);
    run_burst("t3a");
    check("t3_starts", start_cyc.size(), 4);
    check("t3_last_byte", tx_log[3], 8'h13);
    check("t3_tx_empty", tx_count, 3'd0);
    check("t3_no_ovf", rx_overflow, 1'b0);
    push(8'h20);
    run_burst("t3b");
    check("t3_fifth_sent", tx_log[4], 8'h20);
    check("t3_ovf", rx_overflow, 1'b1);
    check("t3_head", rx_data, 8'h10);
    step(); step(); step();
    check("t3_ovf_sticky", rx_overflow, 1'b1);
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    check("t3_ovf_clr", rx_overflow, 1'b0);
    pop_expect("t3_rx0", 8'h10);
    pop_expect("t3_rx1", 8'h11);
    pop_expect("t3_rx2", 8'h12);
    pop_expect("t3_rx3", 8'h13);
    check("t3_rx_empty", rx_empty, 1'b1);

    // ---------------- ack timeout ----------------
    clear_mon();
    eng_ack_en = 1'b0;
    push(8'h55); push(8'h66);
    run_burst("t4");
    check("t4_start_width", start_hi, 15);
    check("t4_starts", start_cyc.size(), 1);
    check("t4_ack_err", ack_error, 1'b1);
    check("t4_flushed", tx_count, 3'd0);
    check("t4_cs", cs_n, 1'b1);
    check("t4_rx_empty", rx_empty, 1'b1);
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    check("t4_ack_clr", ack_error, 1'b0);
    eng_ack_en = 1'b1;

    // ---------------- reset mid-burst ----------------
    clear_mon();
    push(8'h31); push(8'h32); push(8'h33);
    go = 1'b1; step(); go = 1'b0;
    wait_wait_done("t5");
    check("t5_count_mid", tx_count, 3'd2);
    reset = 1'b1; step(); reset = 1'b0;
    check("t5_ctl", {cs_n, spi_start, busy}, 3'b100);
    check("t5_count", tx_count, 3'd0);
    check("t5_rx_empty", rx_empty, 1'b1);
    check("t5_data_tx", spi_data_tx, 8'h00);
    begin
      int n = 0;
      while (eng_busy && n < 50) begin step(); n++; end
    end
    step(); step();
    check("t5_ignore_rx", rx_empty, 1'b1);
    clear_mon();
    go = 1'b1; step(); go = 1'b0;
    step(); step(); step(); step();
    check("t5_go_empty", {cs_n, spi_start, busy}, 3'b100);
    check("t5_no_cs", cs_falls, 0);

    // ---------------- push during last byte ----------------
    clear_mon();
    push(8'h41);
    go = 1'b1; step(); go = 1'b0;
    wait_wait_done("t6");
    push(8'h42);
    finish_burst("t6");
    check("t6_starts", start_cyc.size(), 2);
    check("t6_b1", tx_log[1], 8'h42);
    check("t6_cs_rises", cs_rises, 1);
    pop_expect("t6_rx0", 8'h41);
    pop_expect("t6_rx1", 8'h42);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_burst_sequencer.md
Name: spi_burst_sequencer

Overview:
- Sequences the byte-level SPI engine (start/busy handshake, data_tx/data_rx) so software can queue multi-byte transfers instead of polling per byte.
- Owns chip-select timing, a TX FIFO feeding the engine and an RX FIFO capturing returned bytes.
- Sits between the peripherals register decode and the spi instance, replacing the direct spi_start/spi_tx_buffer drive.

Parameters:
FIFO_DEPTH, 4, entries per TX and RX FIFO; power of two, minimum 2.
CS_SETUP, 2, raw_clk cycles from cs_n falling to first spi_start.
CS_HOLD, 2, raw_clk cycles from last byte done to cs_n rising.
ACK_TIMEOUT, 15, cycles allowed for spi_busy to rise after spi_start before abort.

Ports:
raw_clk  in  1  single clock; all logic on its rising edge
reset  in  1  synchronous, active-high
tx_data  in  8  byte to queue
tx_push  in  1  one-cycle strobe; enqueue tx_data
tx_full  out  1  TX FIFO full
tx_count  out  $clog2(FIFO_DEPTH)+1  TX occupancy
rx_data  out  8  RX FIFO head (valid when rx_empty=0)
rx_pop  in  1  one-cycle strobe; dequeue RX head
rx_empty  out  1  RX FIFO empty
go  in  1  one-cycle strobe; start burst
clear_flags  in  1  clears sticky flags
busy  out  1  high in every state except IDLE
rx_overflow  out  1  sticky: received byte dropped, RX full
ack_error  out  1  sticky: ACK_TIMEOUT expired
cs_n  out  1  chip select, active low
spi_start  out  1  to engine start
spi_data_tx  out  8  to engine data_tx
spi_busy  in  1  from engine busy
spi_data_rx  in  8  from engine data_rx

Behaviour:
- Reset (sync, wins over all inputs): state IDLE, both FIFOs empty (tx_full=0, tx_count=0, rx_empty=1), cs_n=1, spi_start=0, spi_data_tx=0, busy=0, rx_overflow=0, ack_error=0. Reset mid-burst aborts immediately; engine's in-flight byte is ignored.
- TX FIFO: push while full ignored, no flag. Push allowed in any state; bytes queued during a burst go out in the same burst. Push and internal pop in same cycle when not full: both happen, count unchanged.
- RX FIFO: pop while empty ignored. rx_data is combinational from head. Capture and pop in same cycle: pop first, so capture into a full FIFO succeeds with no overflow.
- FSM:
  - IDLE: cs_n=1. go with tx_count>0 -> SETUP, cs_n<=0, counter<=CS_SETUP-1. go with TX empty ignored. go outside IDLE ignored.
  - SETUP: count down; at 0 -> LOAD.
  - LOAD (1 cycle): spi_data_tx<=TX head, pop TX, spi_start<=1, timeout counter<=0 -> WAIT_ACK.
  - WAIT_ACK: spi_busy=1 -> spi_start<=0, go to WAIT_DONE. Counter reaches ACK_TIMEOUT first -> spi_start<=0, ack_error<=1, flush TX FIFO, go to HOLD.
  - WAIT_DONE: spi_busy=0 -> write spi_data_rx to RX FIFO (full and no pop: drop byte, rx_overflow<=1). Then TX non-empty -> LOAD (cs_n stays 0), else HOLD with counter<=CS_HOLD-1.
  - HOLD: count down; at 0 -> cs_n<=1, IDLE.
- spi_data_tx held stable from LOAD until next LOAD.
- Per byte from LOAD: 1 + ack latency + engine busy time. Inter-byte gap is exactly 1 cycle (LOAD) after busy falls.
- Sticky flags: cleared only by clear_flags or reset. clear_flags coinciding with a set event: set wins.
- Counters: CS_SETUP/CS_HOLD of 0 are treated as 1.

Test Plan:
- Reset, push 0xA5, go; model engine echoing byte with 8-cycle busy -> cs_n low 2 cycles before spi_start; spi_data_tx=0xA5; one RX entry 0xA5; cs_n high 2 cycles after busy falls; busy=0.
- Push 0x01,0x02,0x03, go -> cs_n held low across all three; exactly 1-cycle LOAD gap between busy fall and next spi_start; RX pops return 0x01,0x02,0x03.
- 4 pushes fill FIFO, 5th push (0xFF) -> tx_full=1, tx_count=4, 0xFF never transmitted. 5 received bytes with no pops -> 5th dropped, rx_overflow=1 until clear_flags.
- Engine never raises busy -> spi_start drops after 15 cycles, ack_error=1, TX flushed, cs_n returns high after CS_HOLD.
- Assert reset mid-WAIT_DONE with 2 bytes queued -> next cycle cs_n=1, spi_start=0, tx_count=0, rx_empty=1, state IDLE. go with empty TX -> no activity.
- Push during WAIT_DONE of last byte -> burst continues with new byte, no cs_n deassert.
